axi_lite_cfg_regs: RTL and testbench
====================================

// Module: axi_lite_cfg_regs
// PURPOSE
//  Parametrised AXI4-Lite slave register file for the pixel pipeline: holds the config words
//  (viewport, zoom, function select) and exposes status words. Unlike the old fixed 8-reg file:
//  byte strobes, read-only status regs, SLVERR on bad address, and frame-synchronous shadowing,
//  so config never changes mid-frame. Sits between the PS AXI-Lite port and coord_gen/func_eval.
// PARAMETERS
//  NUM_REGS    16      number of 32-bit registers, 2..256
//  ADDR_WIDTH  8       AXI-Lite byte-address width; reg index = addr[2+:$clog2(NUM_REGS)]
//  RO_MASK     0       NUM_REGS-bit mask; bit i=1 -> reg i is read-only, reads status_in word i
//  SHADOW_EN   1       1: cfg_out updates only on frame_start; 0: cfg_out follows writes directly
// PORTS
//  aclk                 in   1               single clock for bus and pixel side
//  areset               in   1               asynchronous, active-high reset
//  s_axi_lite_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1   write address channel
//  s_axi_lite_wdata/wstrb/wvalid/wready in/in/in/out 32/4/1/1     write data channel
//  s_axi_lite_bresp/bvalid/bready     out/out/in 2/1/1            write response
//  s_axi_lite_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1   read address channel
//  s_axi_lite_rdata/rresp/rvalid/rready out/out/out/in 32/2/1/1   read data channel
//  status_in            in   32*NUM_REGS     status words, word i sampled for RO reg i
//  frame_start          in   1               1-cycle pulse at start of frame (tuser/first)
//  cfg_out              out  32*NUM_REGS     active config, word i = reg i (RO words read 0)
//  cfg_update           out  1               1-cycle pulse: active set was reloaded this cycle
// BEHAVIOUR
//  Reset (async assert, sync release): all shadow/active regs 0, pending=0, awready=wready=arready=1,
//   bvalid=rvalid=0, bresp=rresp=OKAY, rdata=0, cfg_update=0. Reset mid-transaction abandons it.
//  Write FSM: IDLE -> {AW only: WDATA | W only: WADDR | both: WRITE}; WDATA/WADDR -> WRITE when the
//   missing channel arrives; WRITE (1 cycle, commit) -> RESP; RESP -> IDLE on bready.
//   awready=IDLE|WADDR, wready=IDLE|WDATA, bvalid=RESP. Both in same cycle: bvalid 2 cycles later.
//  Commit: byte k of shadow[idx] <= wdata[8k+:8] iff wstrb[k]. wstrb=0 -> OKAY, no change.
//   Index >= NUM_REGS (full addr>>2 compared, no aliasing) -> bresp=SLVERR, no write.
//   RO reg -> bresp=SLVERR, no write. Valid commit sets pending.
//  Read FSM: IDLE (arready=1) -> FETCH on arvalid -> READ (rvalid=1) -> IDLE on rready.
//   rvalid 2 cycles after ar handshake; rdata/rresp stable while rvalid && !rready.
//   RW reg -> shadow value (last written, even if not yet active); RO reg -> status_in word
//   sampled in FETCH; out of range -> rdata=0, rresp=SLVERR.
//  Read and write FSMs independent; same-reg read in write's commit cycle returns old value.
//  SHADOW_EN=1: on frame_start && pending, active <= shadow, pending cleared, cfg_update=1 next
//   cycle. frame_start without pending: no reload, no pulse. Commit coincident with frame_start:
//   active takes pre-commit shadow, pending stays 1 (new value goes live next frame).
//  SHADOW_EN=0: active == shadow; cfg_update pulses the cycle after each valid commit.
// STRUCTURE
//  Package axi_lite_pkg: AXI_OKAY=2'b00, AXI_SLVERR=2'b10, wr_state_t, rd_state_t enums.
//  One sub-module natural: axi_lite_wr_ctrl (write FSM, addr/data capture, bresp decode),
//  outputs a commit strobe + index + data + strb; top holds read FSM and reg arrays.
// TESTING
//  AW+W same cycle, addr 0x04, data 0xDEADBEEF, strb F -> bvalid 2 cycles later, OKAY; read 0x04
//   returns 0xDEADBEEF; cfg_out word1 still 0 until frame_start, then 0xDEADBEEF + cfg_update.
//  W first, AW 3 cycles later, strb 4'b0101, data 0x11223344 onto 0xFFFFFFFF -> reg = 0xFF22FF44.
//  Write addr 0x40 with NUM_REGS=16 -> SLVERR, no reg changes; read 0x40 -> rdata 0, SLVERR.
//  RO_MASK bit3, status_in word3=0xA5A5: write 0x0C -> SLVERR; read 0x0C -> 0xA5A5, OKAY.
//  Commit and frame_start same cycle -> active keeps old value, next frame_start loads new.
//  areset mid-RESP with bready=0 and rready=0 -> bvalid=rvalid=0, all regs 0, FSMs idle.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes, channel FSM state types and the register index range helper.
package axi_lite_pkg;

   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_SLVERR = 2'b10;

   typedef enum logic [2:0] {W_IDLE, W_WDATA, W_WADDR, W_WRITE, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_READ} rd_state_t;

   // The full word address is compared so that high address bits never alias onto low registers.
   function automatic logic word_in_range(input logic [31:0] word, input int unsigned num_regs);
      return word < num_regs;
   endfunction

endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// AXI4-Lite write channel controller: captures address and data in either order, decodes the
// response and issues a single-cycle commit strobe to the register array.
module axi_lite_wr_ctrl
   import axi_lite_pkg::*;
#(
   parameter int unsigned         NUM_REGS   = 16,
   parameter int unsigned         ADDR_WIDTH = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
   localparam int unsigned        IDXW       = $clog2(NUM_REGS)
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] awaddr_i,
   input  logic                  awvalid_i,
   output logic                  awready_o,
   input  logic [31:0]           wdata_i,
   input  logic [3:0]            wstrb_i,
   input  logic                  wvalid_i,
   output logic                  wready_o,
   output logic [1:0]            bresp_o,
   output logic                  bvalid_o,
   input  logic                  bready_i,
   output logic                  commit_o,
   output logic [IDXW-1:0]       commit_idx_o,
   output logic [31:0]           commit_data_o,
   output logic [3:0]            commit_strb_o
);

   wr_state_t               state_q;
   logic [ADDR_WIDTH-3:0]   waddr_q;
   logic [31:0]             data_q;
   logic [3:0]              strb_q;
   logic                    awready_q, wready_q, bvalid_q;
   logic [1:0]              bresp_q;
   logic [IDXW-1:0]         idx;
   logic                    bad;
   logic                    unused_addr_lsb;

   assign unused_addr_lsb = ^awaddr_i[1:0];
   assign idx = waddr_q[IDXW-1:0];
   // Out-of-range short-circuits the mask lookup, so a non-power-of-two size is safe.
   assign bad = !word_in_range(32'(waddr_q), NUM_REGS) || RO_MASK[idx];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= W_IDLE;
         waddr_q   <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         bvalid_q  <= 1'b0;
         bresp_q   <= AXI_OKAY;
      end else begin
         case (state_q)
            W_IDLE: begin
               if (awvalid_i) waddr_q <= awaddr_i[ADDR_WIDTH-1:2];
               if (wvalid_i) begin
                  data_q <= wdata_i;
                  strb_q <= wstrb_i;
               end
               if (awvalid_i && wvalid_i) begin
                  state_q   <= W_WRITE;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
               end else if (awvalid_i) begin
                  state_q   <= W_WDATA;
                  awready_q <= 1'b0;
               end else if (wvalid_i) begin
                  state_q  <= W_WADDR;
                  wready_q <= 1'b0;
               end
            end
            W_WDATA: if (wvalid_i) begin
               data_q   <= wdata_i;
               strb_q   <= wstrb_i;
               wready_q <= 1'b0;
               state_q  <= W_WRITE;
            end
            W_WADDR: if (awvalid_i) begin
               waddr_q   <= awaddr_i[ADDR_WIDTH-1:2];
               awready_q <= 1'b0;
               state_q   <= W_WRITE;
            end
            W_WRITE: begin
               bvalid_q <= 1'b1;
               bresp_q  <= bad ? AXI_SLVERR : AXI_OKAY;
               state_q  <= W_RESP;
            end
            W_RESP: if (bready_i) begin
               bvalid_q  <= 1'b0;
               awready_q <= 1'b1;
               wready_q  <= 1'b1;
               state_q   <= W_IDLE;
            end
            default: state_q <= W_IDLE;
         endcase
      end
   end

   // An all-zero strobe is answered OKAY but is not a commit: nothing changes, nothing goes pending.
   assign commit_o      = (state_q == W_WRITE) && !bad && (strb_q != 4'd0);
   assign commit_idx_o  = idx;
   assign commit_data_o = data_q;
   assign commit_strb_o = strb_q;
   assign awready_o     = awready_q;
   assign wready_o      = wready_q;
   assign bvalid_o      = bvalid_q;
   assign bresp_o       = bresp_q;

endmodule

// File: rtl/axi_lite_cfg_regs.sv
// AXI4-Lite config register file with read-only status words and frame-synchronous shadowing
// of the active configuration driven into the pixel pipeline.
module axi_lite_cfg_regs
   import axi_lite_pkg::*;
#(
   parameter int unsigned         NUM_REGS   = 16,
   parameter int unsigned         ADDR_WIDTH = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
   parameter bit                  SHADOW_EN  = 1'b1
)(
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [ADDR_WIDTH-1:0]     s_axi_lite_awaddr,
   input  logic                      s_axi_lite_awvalid,
   output logic                      s_axi_lite_awready,
   input  logic [31:0]               s_axi_lite_wdata,
   input  logic [3:0]                s_axi_lite_wstrb,
   input  logic                      s_axi_lite_wvalid,
   output logic                      s_axi_lite_wready,
   output logic [1:0]                s_axi_lite_bresp,
   output logic                      s_axi_lite_bvalid,
   input  logic                      s_axi_lite_bready,
   input  logic [ADDR_WIDTH-1:0]     s_axi_lite_araddr,
   input  logic                      s_axi_lite_arvalid,
   output logic                      s_axi_lite_arready,
   output logic [31:0]               s_axi_lite_rdata,
   output logic [1:0]                s_axi_lite_rresp,
   output logic                      s_axi_lite_rvalid,
   input  logic                      s_axi_lite_rready,
   input  logic [NUM_REGS-1:0][31:0] status_in,
   input  logic                      frame_start,
   output logic [NUM_REGS-1:0][31:0] cfg_out,
   output logic                      cfg_update
);

   localparam int unsigned IDXW = $clog2(NUM_REGS);

   logic                      commit;
   logic [IDXW-1:0]           commit_idx;
   logic [31:0]               commit_data;
   logic [3:0]                commit_strb;
   logic [NUM_REGS-1:0][31:0] shadow_q;

   rd_state_t                 rd_state_q;
   logic [ADDR_WIDTH-3:0]     raddr_q;
   logic                      arready_q, rvalid_q;
   logic [31:0]               rdata_q;
   logic [1:0]                rresp_q;
   logic [IDXW-1:0]           rd_idx;
   logic                      unused_araddr_lsb;

   axi_lite_wr_ctrl #(
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RO_MASK    (RO_MASK)
   ) u_wr_ctrl (
      .clk_i         (aclk),
      .rst_i         (areset),
      .awaddr_i      (s_axi_lite_awaddr),
      .awvalid_i     (s_axi_lite_awvalid),
      .awready_o     (s_axi_lite_awready),
      .wdata_i       (s_axi_lite_wdata),
      .wstrb_i       (s_axi_lite_wstrb),
      .wvalid_i      (s_axi_lite_wvalid),
      .wready_o      (s_axi_lite_wready),
      .bresp_o       (s_axi_lite_bresp),
      .bvalid_o      (s_axi_lite_bvalid),
      .bready_i      (s_axi_lite_bready),
      .commit_o      (commit),
      .commit_idx_o  (commit_idx),
      .commit_data_o (commit_data),
      .commit_strb_o (commit_strb)
   );

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         shadow_q <= '0;
      end else if (commit) begin
         for (int k = 0; k < 4; k++)
            if (commit_strb[k]) shadow_q[commit_idx][8*k +: 8] <= commit_data[8*k +: 8];
      end
   end

   assign unused_araddr_lsb = ^s_axi_lite_araddr[1:0];
   assign rd_idx = raddr_q[IDXW-1:0];

   // FETCH samples shadow before a same-edge commit lands, so a colliding read sees the old value.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rd_state_q <= R_IDLE;
         raddr_q    <= '0;
         arready_q  <= 1'b1;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= AXI_OKAY;
      end else begin
         case (rd_state_q)
            R_IDLE: if (s_axi_lite_arvalid) begin
               raddr_q    <= s_axi_lite_araddr[ADDR_WIDTH-1:2];
               arready_q  <= 1'b0;
               rd_state_q <= R_FETCH;
            end
            R_FETCH: begin
               rvalid_q   <= 1'b1;
               rd_state_q <= R_READ;
               if (!word_in_range(32'(raddr_q), NUM_REGS)) begin
                  rdata_q <= '0;
                  rresp_q <= AXI_SLVERR;
               end else begin
                  rdata_q <= RO_MASK[rd_idx] ? status_in[rd_idx] : shadow_q[rd_idx];
                  rresp_q <= AXI_OKAY;
               end
            end
            R_READ: if (s_axi_lite_rready) begin
               rvalid_q   <= 1'b0;
               arready_q  <= 1'b1;
               rd_state_q <= R_IDLE;
            end
            default: rd_state_q <= R_IDLE;
         endcase
      end
   end

   assign s_axi_lite_arready = arready_q;
   assign s_axi_lite_rvalid  = rvalid_q;
   assign s_axi_lite_rdata   = rdata_q;
   assign s_axi_lite_rresp   = rresp_q;

   if (SHADOW_EN) begin : g_shadow
      logic [NUM_REGS-1:0][31:0] active_q;
      logic                      pending_q, update_q;

      // A commit on the reload edge is not part of this frame's set; it stays pending.
      always_ff @(posedge aclk or posedge areset) begin
         if (areset) begin
            active_q  <= '0;
            pending_q <= 1'b0;
            update_q  <= 1'b0;
         end else begin
            update_q <= 1'b0;
            if (frame_start && pending_q) begin
               active_q  <= shadow_q;
               pending_q <= commit;
               update_q  <= 1'b1;
            end else if (commit) begin
               pending_q <= 1'b1;
            end
         end
      end
      assign cfg_out    = active_q;
      assign cfg_update = update_q;
   end else begin : g_direct
      logic update_q;
      logic unused_frame_start;

      assign unused_frame_start = frame_start;
      always_ff @(posedge aclk or posedge areset) begin
         if (areset) update_q <= 1'b0;
         else        update_q <= commit;
      end
      assign cfg_out    = shadow_q;
      assign cfg_update = update_q;
   end

endmodule

// File: tb/tb_axi_lite_cfg_regs.sv
// Directed plus randomized bench for axi_lite_cfg_regs against a register-array reference model.
module tb_axi_lite_cfg_regs;

   localparam int unsigned    NR = 16;
   localparam int unsigned    AW = 8;
   localparam logic [NR-1:0]  RO = 16'h0008;
   localparam logic [1:0]     OKAY = 2'b00;
   localparam logic [1:0]     SLVERR = 2'b10;

   logic                aclk = 1'b0;
   logic                areset;
   logic [AW-1:0]       awaddr, araddr;
   logic                awvalid, awready, wvalid, wready, bvalid, bready;
   logic                arvalid, arready, rvalid, rready;
   logic [31:0]         wdata, rdata;
   logic [3:0]          wstrb;
   logic [1:0]          bresp, rresp;
   logic [NR-1:0][31:0] status_in, cfg_out;
   logic                frame_start, cfg_update;

   logic [31:0] m_shadow [NR];
   logic [31:0] m_active [NR];
   logic [31:0] m_status [NR];
   bit          m_pending;

   int checks = 0;
   int errors = 0;

   axi_lite_cfg_regs #(
      .NUM_REGS (NR), .ADDR_WIDTH (AW), .RO_MASK (RO), .SHADOW_EN (1'b1)
   ) dut (
      .aclk (aclk), .areset (areset),
      .s_axi_lite_awaddr (awaddr), .s_axi_lite_awvalid (awvalid), .s_axi_lite_awready (awready),
      .s_axi_lite_wdata (wdata), .s_axi_lite_wstrb (wstrb), .s_axi_lite_wvalid (wvalid),
      .s_axi_lite_wready (wready), .s_axi_lite_bresp (bresp), .s_axi_lite_bvalid (bvalid),
      .s_axi_lite_bready (bready), .s_axi_lite_araddr (araddr), .s_axi_lite_arvalid (arvalid),
      .s_axi_lite_arready (arready), .s_axi_lite_rdata (rdata), .s_axi_lite_rresp (rresp),
      .s_axi_lite_rvalid (rvalid), .s_axi_lite_rready (rready),
      .status_in (status_in), .frame_start (frame_start),
      .cfg_out (cfg_out), .cfg_update (cfg_update)
   );

   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [NR-1:0][31:0] exp_cfg();
      logic [NR-1:0][31:0] e;
      for (int i = 0; i < NR; i++) e[i] = m_active[i];
      return e;
   endfunction

   task automatic chk_cfg(input string tag);
      logic [NR-1:0][31:0] e;
      e = exp_cfg();
      checks++;
      assert (cfg_out === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, cfg_out, e);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
      end
      m_pending = 1'b0;
   endtask

   // Called 1 time unit after a rising edge; returns at the same phase.
   task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly, input bit fs_at_commit);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs, ok, exp_upd;
      int cyc = 0;
      int idx;
      logic [31:0] mask;
      awaddr = addr; wdata = data; wstrb = strb;
      while (!(aw_done && w_done) && cyc < 50) begin
         awvalid = !aw_done && cyc >= aw_dly;
         wvalid  = !w_done && cyc >= w_dly;
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick();
         if (aw_hs) aw_done = 1;
         if (w_hs) w_done = 1;
         cyc++;
      end
      awvalid = 0; wvalid = 0;
      chk("wr_handshake", {31'd0, aw_done && w_done}, 32'd1);
      chk("bvalid_early", {31'd0, bvalid}, 32'd0);
      if (fs_at_commit) frame_start = 1;
      idx = int'(addr) / 4;
      ok = 0;
      if (idx < NR) ok = !RO[idx];
      exp_upd = fs_at_commit && m_pending;
      if (exp_upd) begin
         for (int i = 0; i < NR; i++) m_active[i] = m_shadow[i];
         m_pending = 0;
      end
      if (ok && strb != 4'd0) begin
         mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
         m_shadow[idx] = (m_shadow[idx] & ~mask) | (data & mask);
         m_pending = 1;
      end
      tick();
      frame_start = 0;
      chk("bvalid", {31'd0, bvalid}, 32'd1);
      chk("bresp", {30'd0, bresp}, {30'd0, ok ? OKAY : SLVERR});
      chk("cfg_update_wr", {31'd0, cfg_update}, {31'd0, exp_upd});
      chk_cfg("cfg_after_wr");
      for (int i = 0; i < b_dly; i++) begin
         tick();
         chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
      end
      bready = 1;
      tick();
      bready = 0;
      chk("bvalid_clear", {31'd0, bvalid}, 32'd0);
      chk("awready_back", {31'd0, awready && wready}, 32'd1);
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input int r_dly);
      bit hs = 0;
      int cyc = 0;
      int idx;
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      idx = int'(addr) / 4;
      if (idx >= NR) begin exp_d = '0; exp_r = SLVERR; end
      else if (RO[idx]) begin exp_d = m_status[idx]; exp_r = OKAY; end
      else begin exp_d = m_shadow[idx]; exp_r = OKAY; end
      araddr = addr;
      arvalid = 1;
      while (!hs && cyc < 50) begin
         hs = arready;
         tick();
         cyc++;
      end
      arvalid = 0;
      chk("rd_handshake", {31'd0, hs}, 32'd1);
      chk("rvalid_early", {31'd0, rvalid}, 32'd0);
      tick();
      chk("rvalid", {31'd0, rvalid}, 32'd1);
      chk("rdata", rdata, exp_d);
      chk("rresp", {30'd0, rresp}, {30'd0, exp_r});
      for (int i = 0; i < r_dly; i++) begin
         tick();
         chk("rdata_hold", rdata, exp_d);
         chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
      end
      rready = 1;
      tick();
      rready = 0;
      chk("rvalid_clear", {31'd0, rvalid}, 32'd0);
   endtask

   task automatic do_frame();
      bit exp_upd;
      exp_upd = m_pending;
      if (m_pending) begin
         for (int i = 0; i < NR; i++) m_active[i] = m_shadow[i];
         m_pending = 0;
      end
      frame_start = 1;
      tick();
      frame_start = 0;
      chk("cfg_update_frame", {31'd0, cfg_update}, {31'd0, exp_upd});
      chk_cfg("cfg_after_frame");
      tick();
      chk("cfg_update_pulse", {31'd0, cfg_update}, 32'd0);
   endtask

   initial begin
      int op;
      areset = 1;
      awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
      araddr = '0; arvalid = 0; rready = 0; frame_start = 0;
      for (int i = 0; i < NR; i++) m_status[i] = $urandom;
      m_status[3] = 32'h0000_A5A5;
      for (int i = 0; i < NR; i++) status_in[i] = m_status[i];
      model_reset();
      repeat (2) @(posedge aclk);
      #1;
      chk("rst_awready", {31'd0, awready}, 32'd1);
      chk("rst_wready", {31'd0, wready}, 32'd1);
      chk("rst_arready", {31'd0, arready}, 32'd1);
      chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_resp", {28'd0, bresp, rresp}, 32'd0);
      chk("rst_cfg_update", {31'd0, cfg_update}, 32'd0);
      chk_cfg("rst_cfg_out");
      areset = 0;
      tick();

      // Same-cycle AW/W, read back before and after the frame reload
      do_write(8'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
      do_read(8'h04, 0);
      do_frame();
      chk("cfg_word1", cfg_out[1], 32'hDEAD_BEEF);

      // W ahead of AW by three cycles, partial strobe over all-ones
      do_write(8'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 1, 0);
      do_write(8'h08, 32'h1122_3344, 4'b0101, 3, 0, 0, 0);
      do_read(8'h08, 2);
      chk("strobe_merge", m_shadow[2], 32'hFF22_FF44);

      // Out-of-range and read-only targets
      do_write(8'h40, 32'h1234_5678, 4'hF, 0, 0, 0, 0);
      do_read(8'h40, 1);
      do_write(8'h0C, 32'h5555_5555, 4'hF, 1, 0, 0, 0);
      do_read(8'h0C, 0);

      // Zero strobe leaves the register untouched
      do_frame();
      do_write(8'h04, 32'h0BAD_0BAD, 4'h0, 0, 2, 0, 0);
      do_read(8'h04, 0);

      // Commit colliding with frame_start goes live one frame later
      do_write(8'h14, 32'h0000_1111, 4'hF, 0, 0, 0, 0);
      do_frame();
      do_write(8'h14, 32'h0000_2222, 4'hF, 0, 0, 0, 0);
      do_write(8'h14, 32'h0000_3333, 4'hF, 0, 0, 0, 1);
      chk("collide_active", cfg_out[5], 32'h0000_2222);
      do_frame();
      chk("collide_next", cfg_out[5], 32'h0000_3333);
      do_frame();

      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 3);
         if (op <= 1)
            do_write(AW'($urandom_range(0, 18) * 4), $urandom, 4'($urandom_range(1, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                     ($urandom_range(0, 7) == 0));
         else if (op == 2)
            do_read(AW'($urandom_range(0, 18) * 4), $urandom_range(0, 2));
         else
            do_frame();
      end

      // Reset while both response channels are stalled
      awaddr = 8'h18; wdata = 32'hCAFE_F00D; wstrb = 4'hF; araddr = 8'h04;
      awvalid = 1; wvalid = 1; arvalid = 1;
      tick();
      awvalid = 0; wvalid = 0; arvalid = 0;
      tick();
      chk("pre_rst_valids", {30'd0, bvalid, rvalid}, 32'd3);
      #2 areset = 1;
      #1;
      chk("mid_rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
      chk("mid_rst_readys", {29'd0, awready, wready, arready}, 32'd7);
      chk("mid_rst_cfg_update", {31'd0, cfg_update}, 32'd0);
      model_reset();
      chk_cfg("mid_rst_cfg_out");
      @(posedge aclk);
      #1 areset = 0;
      tick();
      do_read(8'h04, 0);
      do_read(8'h18, 0);
      do_frame();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
